// File: rtl/match_pkg.sv
// Shared types and widths for the round/match sequencer.
package match_pkg;

  localparam int unsigned SCORE_W = 3;
  localparam int unsigned ROUND_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_RESULT    = 3'd2,
    ST_RESET     = 3'd3,
    ST_MATCH_END = 3'd4
  } match_state_t;

  // Increment a round-win score, holding at the match limit.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] score,
                                                   input logic [SCORE_W-1:0] limit);
    return (score >= limit) ? score : score + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; done_c flags the final counted cycle.
module pulse_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // A load of N keeps the owning state active for exactly N cycles.
  assign done_c = (count <= W'(1));

endmodule

// File: rtl/match_ctrl.sv
// Round/match sequencer: scores rounds, holds results, soft-resets the game
// controller between rounds and declares a champion.
module match_ctrl
  import match_pkg::*;
#(
  parameter int unsigned WIN_ROUNDS  = 3,
  parameter int unsigned HOLD_CYCLES = 200_000_000,
  parameter int unsigned RST_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               game_start,
  input  logic               game_over,
  input  logic               p1_win,
  input  logic               match_restart,
  output logic               game_reset,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [ROUND_W-1:0] round_num,
  output logic               match_over,
  output logic               p1_champion
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RSTC_W = $clog2(RST_CYCLES + 1);
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_ROUNDS);
  localparam logic [ROUND_W-1:0] ROUND_MAX = {ROUND_W{1'b1}};
  localparam logic [ROUND_W-1:0] ROUND_FIRST = ROUND_W'(1);

  match_state_t state, state_next;

  logic               go_prev, mr_prev;
  logic               go_rise_c, mr_rise_c, abort_c;
  logic               hold_load_c, hold_done_c, rst_load_c, rst_done_c;
  logic [SCORE_W-1:0] p1_next_c, p2_next_c, win_next_c;
  logic               match_won_c;

  logic               game_reset_d, match_over_d, p1_champion_d;
  logic [SCORE_W-1:0] p1_score_d, p2_score_d;
  logic [ROUND_W-1:0] round_num_d;

  assign go_rise_c   = game_over & ~go_prev;
  assign mr_rise_c   = match_restart & ~mr_prev;
  assign abort_c     = mr_rise_c && (state != ST_RESET);
  assign p1_next_c   = score_inc(p1_score, WIN_SCORE);
  assign p2_next_c   = score_inc(p2_score, WIN_SCORE);
  assign win_next_c  = p1_win ? p1_next_c : p2_next_c;
  assign match_won_c = (win_next_c == WIN_SCORE);

  // Timers are only (re)loaded on entry to their state.
  assign hold_load_c = (state_next == ST_RESULT) && (state != ST_RESULT);
  assign rst_load_c  = (state_next == ST_RESET) && (state != ST_RESET);

  pulse_timer #(.W(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (hold_load_c),
    .load_val (HOLD_W'(HOLD_CYCLES)),
    .done_c   (hold_done_c)
  );

  pulse_timer #(.W(RSTC_W)) u_rst_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (rst_load_c),
    .load_val (RSTC_W'(RST_CYCLES)),
    .done_c   (rst_done_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (abort_c)         state_next = ST_RESET;
        else if (game_start) state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (abort_c)          state_next = ST_RESET;
        else if (go_rise_c)   state_next = match_won_c ? ST_MATCH_END : ST_RESULT;
        else if (!game_start) state_next = ST_IDLE;
      end
      ST_RESULT: begin
        if (abort_c || hold_done_c) state_next = ST_RESET;
      end
      ST_RESET: begin
        if (rst_done_c) state_next = ST_IDLE;
      end
      ST_MATCH_END: begin
        if (abort_c) state_next = ST_RESET;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; restart outranks scoring.
  always_comb begin
    game_reset_d  = (state_next == ST_RESET);
    p1_score_d    = p1_score;
    p2_score_d    = p2_score;
    round_num_d   = round_num;
    match_over_d  = match_over;
    p1_champion_d = p1_champion;
    if (abort_c) begin
      p1_score_d    = '0;
      p2_score_d    = '0;
      round_num_d   = ROUND_FIRST;
      match_over_d  = 1'b0;
      p1_champion_d = 1'b0;
    end else if ((state == ST_PLAY) && go_rise_c) begin
      if (p1_win) p1_score_d = p1_next_c;
      else        p2_score_d = p2_next_c;
      if (match_won_c) begin
        match_over_d  = 1'b1;
        p1_champion_d = p1_win;
      end
    end else if ((state == ST_RESULT) && hold_done_c) begin
      round_num_d = (round_num == ROUND_MAX) ? round_num : round_num + ROUND_W'(1);
    end
  end

  // A game_over level held across RESET must never count as a new edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      go_prev     <= 1'b0;
      mr_prev     <= 1'b1;
      game_reset  <= 1'b0;
      p1_score    <= '0;
      p2_score    <= '0;
      round_num   <= ROUND_FIRST;
      match_over  <= 1'b0;
      p1_champion <= 1'b0;
    end else begin
      go_prev     <= (state_next == ST_RESET) ? 1'b1 : game_over;
      mr_prev     <= match_restart;
      game_reset  <= game_reset_d;
      p1_score    <= p1_score_d;
      p2_score    <= p2_score_d;
      round_num   <= round_num_d;
      match_over  <= match_over_d;
      p1_champion <= p1_champion_d;
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: a driver plays the game controller and
// queues expected output changes; a monitor pops them as the DUT shows them.
module tb_match_ctrl;

  localparam int unsigned WIN  = 2;
  localparam int unsigned HOLD = 10;
  localparam int unsigned RSTC = 3;

  logic clk = 1'b0, rstn = 1'b0;
  logic game_start = 1'b0, game_over = 1'b0, p1_win = 1'b0, match_restart = 1'b0;
  logic       game_reset, match_over, p1_champion;
  logic [2:0] p1_score, p2_score;
  logic [3:0] round_num;

  int checks = 0, failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [11:0] t;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];

  localparam logic [11:0] RST_TUPLE = {3'd0, 3'd0, 4'd1, 1'b0, 1'b0};

  int         m_p1, m_p2, m_round;
  bit         m_mo, m_ch;
  logic [11:0] m_last;

  match_ctrl #(.WIN_ROUNDS(WIN), .HOLD_CYCLES(HOLD), .RST_CYCLES(RSTC)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .game_start    (game_start),
    .game_over     (game_over),
    .p1_win        (p1_win),
    .match_restart (match_restart),
    .game_reset    (game_reset),
    .p1_score      (p1_score),
    .p2_score      (p2_score),
    .round_num     (round_num),
    .match_over    (match_over),
    .p1_champion   (p1_champion)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- reference model (event level) ----------------
  function automatic logic [11:0] model_tuple();
    return {3'(m_p1), 3'(m_p2), 4'(m_round), m_mo, m_ch};
  endfunction

  task automatic push_tuple(input int stamp);
    logic [11:0] t;
    exp_t e;
    t = model_tuple();
    if (t != m_last) begin
      e.t = t;
      e.cyc = 32'(stamp);
      exp_q.push_back(e);
      m_last = t;
    end
  endtask

  task automatic model_clear(input int stamp);
    m_p1 = 0; m_p2 = 0; m_round = 1; m_mo = 1'b0; m_ch = 1'b0;
    push_tuple(stamp);
    pulse_q.push_back(stamp);
  endtask

  task automatic model_score(input int stamp, input bit p1w, output bit ended);
    if (p1w) m_p1 = (m_p1 >= int'(WIN)) ? m_p1 : m_p1 + 1;
    else     m_p2 = (m_p2 >= int'(WIN)) ? m_p2 : m_p2 + 1;
    ended = p1w ? (m_p1 == int'(WIN)) : (m_p2 == int'(WIN));
    if (ended) begin
      m_mo = 1'b1;
      m_ch = p1w;
    end
    push_tuple(stamp);
  endtask

  task automatic model_hold(input int stamp);
    pulse_q.push_back(stamp + int'(HOLD));
    m_round = (m_round < 15) ? m_round + 1 : 15;
    push_tuple(stamp + int'(HOLD));
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [11:0] last_t, cur_t;
    logic        gr_prev;
    int          gr_width;
    exp_t        e;
    int          ps;
    last_t = RST_TUPLE;
    gr_prev = 1'b0;
    gr_width = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur_t = {p1_score, p2_score, round_num, match_over, p1_champion};
        if (cur_t !== last_t) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output_change actual=%h required=%h (cycle %0d)", cur_t, last_t, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("output_tuple", 32'(cur_t), 32'(e.t));
            chk("output_tuple_cycle", 32'(cyc), e.cyc);
          end
          last_t = cur_t;
        end
        if (game_reset && !gr_prev) begin
          if (pulse_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_game_reset actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            ps = pulse_q.pop_front();
            chk("game_reset_start_cycle", 32'(cyc), 32'(ps));
          end
          gr_width = 1;
        end else if (game_reset) begin
          gr_width++;
        end else if (gr_prev) begin
          chk("game_reset_width", 32'(gr_width), 32'(RSTC));
        end
        gr_prev = game_reset;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_gr(input logic lvl, input string nm);
    int n;
    n = 0;
    while (game_reset !== lvl && n < 100) begin
      tick();
      n++;
    end
    if (game_reset !== lvl) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=%0b required=%0b", nm, game_reset, lvl);
    end
  endtask

  // Behave like the game controller: drop its status within 2 cycles of game_reset.
  task automatic finish_reset(input bit keep_go, input bit keep_start);
    wait_gr(1'b1, "game_reset_rise");
    if ($urandom_range(0, 1) == 1) tick();
    match_restart = 1'b0;
    if (!keep_start) game_start = 1'b0;
    if (!keep_go)    game_over  = 1'b0;
    wait_gr(1'b0, "game_reset_fall");
    tick();
  endtask

  // kind: 0 restart in idle, 1 abandon, 2 simultaneous, 3 abort at hold 5,
  // 4 abort at random hold cycle, 5..9 normal round. -1 = random.
  task automatic play_round(input int kind_in, input int p1w_in, input int stale_in);
    int kind, c, k;
    bit p1w, stale, keep_start, ended;
    kind       = (kind_in < 0) ? int'($urandom_range(0, 9)) : kind_in;
    p1w        = (p1w_in < 0) ? 1'($urandom_range(0, 1)) : 1'(p1w_in);
    stale      = (stale_in < 0) ? ($urandom_range(0, 2) == 0) : (stale_in != 0);
    keep_start = ($urandom_range(0, 3) == 0);
    repeat ($urandom_range(0, 3)) tick();
    if (kind == 0) begin
      match_restart = 1'b1;
      model_clear(cyc + 1);
      tick();
      finish_reset(stale, keep_start);
      return;
    end
    game_start = 1'b1;
    tick();
    repeat ($urandom_range(0, 3)) tick();
    if (game_over) begin
      repeat ($urandom_range(1, 3)) tick();
      game_over = 1'b0;
      tick();
    end
    if (kind == 1) begin
      game_start = 1'b0;
      tick();
      tick();
      return;
    end
    p1_win    = p1w;
    game_over = 1'b1;
    c = cyc + 1;
    if (kind == 2) begin
      match_restart = 1'b1;
      model_clear(c);
      tick();
      finish_reset(stale, keep_start);
      return;
    end
    model_score(c, p1w, ended);
    tick();
    if (ended) begin
      repeat ($urandom_range(2, 12)) tick();
      match_restart = 1'b1;
      model_clear(cyc + 1);
      tick();
      finish_reset(stale, keep_start);
      return;
    end
    if (kind == 3 || kind == 4) begin
      k = (kind == 3) ? 5 : int'($urandom_range(1, HOLD - 1));
      repeat (k - 1) tick();
      match_restart = 1'b1;
      model_clear(cyc + 1);
      tick();
      finish_reset(stale, keep_start);
      return;
    end
    model_hold(c);
    finish_reset(stale, keep_start);
  endtask

  initial begin : driver
    bit seen;
    int w;
    repeat (3) tick();
    chk("reset_game_reset", 32'(game_reset), 0);
    rstn = 1'b1;
    tick();
    chk("reset_p1_score", 32'(p1_score), 0);
    chk("reset_p2_score", 32'(p2_score), 0);
    chk("reset_round_num", 32'(round_num), 1);
    chk("reset_match_over", 32'(match_over), 0);
    chk("reset_p1_champion", 32'(p1_champion), 0);

    m_p1 = 0; m_p2 = 0; m_round = 1; m_mo = 1'b0; m_ch = 1'b0;
    m_last = RST_TUPLE;
    mon_en = 1'b1;

    play_round(5, 1, 0);
    play_round(5, 0, 0);
    play_round(5, 0, 1);
    play_round(3, -1, 0);
    play_round(2, -1, 0);
    play_round(5, -1, 1);
    play_round(5, -1, 0);
    repeat (60) play_round(-1, -1, -1);

    // Async reset in the middle of a game_reset pulse.
    game_start = 1'b0;
    game_over  = 1'b0;
    repeat (3) tick();
    match_restart = 1'b1;
    model_clear(cyc + 1);
    tick();
    wait_gr(1'b1, "final_pulse_rise");
    #2 mon_en = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("async_game_reset", 32'(game_reset), 0);
    chk("async_scores", 32'({p1_score, p2_score}), 0);
    chk("async_round_num", 32'(round_num), 1);
    chk("async_match_flags", 32'({match_over, p1_champion}), 0);
    tick();
    rstn = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (game_reset) seen = 1'b1;
    end
    chk("held_restart_no_edge", 32'(seen), 0);
    match_restart = 1'b0;
    repeat (2) tick();
    match_restart = 1'b1;
    tick();
    chk("restart_after_reset_pulse", 32'(game_reset), 1);
    w = 0;
    while (game_reset && w < 20) begin
      w++;
      tick();
    end
    chk("restart_after_reset_width", 32'(w), 32'(RSTC));
    match_restart = 1'b0;
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("pulse_queue_drained", 32'(pulse_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Round/match sequencer sitting directly downstream of the game controller: consumes its `game_start`, `game_over` and `p1_win` status and drives its `game_reset` input back. Keeps per-player round wins and a round counter, holds each round result on screen for a fixed time, then soft-resets the game for the next round. Declares a champion at first-to-`WIN_ROUNDS` and waits for a restart request.

## Interface
- `WIN_ROUNDS`, 3: round wins needed for the match (1..7).
- `HOLD_CYCLES`, 200_000_000: result display time in `clk` cycles (2 s at 100 MHz); must be ≥1.
- `RST_CYCLES`, 4: width of the `game_reset` pulse in cycles; must be ≥2.
- `clk`  in  1  system clock, 100 MHz, same domain as the game controller.
- `rstn`  in  1  asynchronous, active-low reset.
- `game_start`  in  1  level: round in progress.
- `game_over`  in  1  level: round finished.
- `p1_win`  in  1  valid while `game_over`=1; 1 means P1 won the round.
- `match_restart`  in  1  debounced, synchronous button level; rising edge acts.
- `game_reset`  out  1  registered soft-reset request to the game controller.
- `p1_score`  out  3  P1 round wins.
- `p2_score`  out  3  P2 round wins.
- `round_num`  out  4  current round, 1-based.
- `match_over`  out  1  champion decided.
- `p1_champion`  out  1  valid while `match_over`=1; 1 means P1 won the match.

## Operation
- States: IDLE, PLAY, RESULT, RESET, MATCH_END.
- IDLE: `game_start`=1 → PLAY. `game_over` is ignored, even if it is stale-high.
- PLAY:
  - Rising edge of `game_over` (prev 0, now 1): winner's score increments, saturating at `WIN_ROUNDS`.
  - If the new score equals `WIN_ROUNDS`: set `match_over`, set `p1_champion`=`p1_win`, go to MATCH_END.
  - Otherwise go to RESULT and load the hold counter.
  - `game_start` falls without `game_over` → IDLE, no score change.
- RESULT: counts `HOLD_CYCLES`, then → RESET and `round_num` increments, saturating at 15.
- RESET: `game_reset`=1 for exactly `RST_CYCLES` cycles, then → IDLE.
- MATCH_END: outputs are frozen. A rising edge of `match_restart` → RESET.
- Restart clear: a `match_restart` rising edge in IDLE, PLAY, RESULT or MATCH_END aborts the match.
  - Clears both scores, `match_over` and `p1_champion`.
  - Sets `round_num`=1.
  - Enters RESET.
- A restart edge during RESET is ignored.
- Restart has priority over a `game_over` edge arriving in the same cycle: no score is awarded.
- Edge detectors:
  - `game_over` previous-value register resets to 0 and is forced to 1 while in RESET. A level still held from the old round therefore never counts.
  - `match_restart` previous-value register resets to 1, so a button held through reset is not an edge.
- Width rules: scores are 3-bit unsigned. The hold counter is `$clog2(HOLD_CYCLES+1)` bits and the reset counter `$clog2(RST_CYCLES+1)` bits; both count down and both are only loaded on state entry.

## Timing
- Reset values: `game_reset`=0, `p1_score`=`p2_score`=0, `round_num`=1, `match_over`=0, `p1_champion`=0, state IDLE.
- Asynchronous assert; all other behaviour is synchronous to `clk`.
- `game_over` rises at sampled cycle N:
  - score, `match_over` and `p1_champion` update at edge N+1, visible in cycle N+1.
  - State is RESULT or MATCH_END from N+1.
- `game_reset` rises exactly `HOLD_CYCLES` cycles after the score update and stays high `RST_CYCLES` consecutive cycles.
- State is IDLE in the cycle after `game_reset` falls.
- `match_restart` rising edge sampled at cycle M: `game_reset`=1 and scores cleared from M+1.
- The game controller delays `game_reset` by one register, so `game_start` and `game_over` drop up to 2 cycles after `game_reset` rises. `RST_CYCLES`≥2 covers this.
- The next round starts when `game_start` re-asserts after RESET. If both ready inputs are held, this happens immediately.

## Structure
- Package `match_pkg`:
  - `match_state_t` enum, one-hot-free 3-bit encoding.
  - `SCORE_W`=3, `ROUND_W`=4.
- Sub-module `pulse_timer`: loadable down-counter with a `done` flag, parameterised width. It is instantiated twice, as the hold timer and the reset-pulse timer.
- The FSM, score registers and edge detectors stay in `match_ctrl`.

## Test plan
Bench parameters unless noted: `WIN_ROUNDS`=2, `HOLD_CYCLES`=10, `RST_CYCLES`=3.
- Single round: assert `game_start`, then `game_over`=1 with `p1_win`=1 → `p1_score`=1 one cycle later. `game_reset` high cycles 11–13 after that; `round_num`=2; state IDLE.
- Match win: P2 wins two rounds → `p2_score`=2, `match_over`=1, `p1_champion`=0. No `game_reset` until `match_restart` rises, then 3-cycle pulse; scores 0, `round_num`=1.
- Stale `game_over`: hold `game_over` high through RESET and into the next PLAY → no second score increment until it falls and rises again.
- Abort mid-hold: `match_restart` edge at RESULT cycle 5 → scores 0, `round_num`=1, `game_reset` pulse starts next cycle. The original hold never fires a second pulse.
- Simultaneous: `game_over` rise and `match_restart` edge in the same PLAY cycle → no score awarded; RESET entered; scores 0.
- Async reset: `rstn` low mid-RESET pulse → `game_reset`=0 immediately, all outputs at reset values. A `match_restart` held high across reset release produces no edge.
